// File: rtl/uart_rx_frontend.sv
// 8N1 serial receiver: two-flop input synchroniser, mid-bit sampling, start-bit
// glitch rejection, framing-error pulse and break (line-held-low) lockout.
module uart_rx_frontend #(
    parameter int CLKS_PER_BIT = 434,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic       rx_new_o,
    output logic [7:0] rx_data_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    sh, sh_n;
    logic [7:0]    data_n;
    logic          new_n, err_n;
    logic          rx_meta, rx_s;

    // Synchroniser flops reset high so a reset never looks like a start bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            sh          <= '0;
            rx_data_o   <= '0;
            rx_new_o    <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            sh          <= sh_n;
            rx_data_o   <= data_n;
            rx_new_o    <= new_n;
            frame_err_o <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        sh_n    = sh;
        data_n  = rx_data_o;
        new_n   = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                cnt_n = cnt + 1'b1;
                if (cnt == HALF_LAST) begin
                    cnt_n = '0;
                    if (!rx_s) begin
                        state_n = DATA;
                        idx_n   = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DATA: begin
                cnt_n = cnt + 1'b1;
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    sh_n  = {rx_s, sh[7:1]};
                    if (idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end
            end
            STOP: begin
                cnt_n = cnt + 1'b1;
                // Leaving at the stop-bit midpoint lets an immediate next start bit be caught.
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        data_n  = sh;
                        new_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        err_n   = 1'b1;
                        state_n = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend: stimulus pushes expected pulses into a
// queue, a negedge monitor pops and compares each rx_new/frame_err pulse.
module tb_uart_rx_frontend;

    localparam int CPB = 16;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_new;
    logic [7:0] rx_data;
    logic       frame_err;
    logic       busy;

    exp_t exp_q[$];
    int   n_vectors = 0;
    int   n_miscompares = 0;
    int   events_seen = 0;
    int   cycle = 0;
    int   prev_new_cycle = 0;
    int   last_new_cycle = 0;
    bit   x_seen = 1'b0;

    uart_rx_frontend #(.CLKS_PER_BIT(CPB)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .rx_i       (rx),
        .rx_new_o   (rx_new),
        .rx_data_o  (rx_data),
        .frame_err_o(frame_err),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every output pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if ($isunknown({rx_new, frame_err, busy, rx_data})) x_seen = 1'b1;
        if (rst_n && (rx_new || frame_err)) begin
            exp_t e;
            events_seen++;
            check_output("pulse_exclusive", {31'd0, rx_new & frame_err}, 32'd0);
            if (rx_new) begin
                prev_new_cycle = last_new_cycle;
                last_new_cycle = cycle;
            end
            if (exp_q.size() == 0) begin
                check_output("unexpected_pulse", {31'd0, frame_err}, 32'hffff_ffff);
            end else begin
                e = exp_q.pop_front();
                check_output("pulse_kind", {31'd0, frame_err}, {31'd0, e.is_err});
                check_output("rx_data_at_pulse", {24'd0, rx_data}, {24'd0, e.data});
            end
        end
    end

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic [7:0] data, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
        drive_bit(stop_bit);
    endtask

    task automatic wait_events(input int target, input int budget);
        for (int i = 0; i < budget && events_seen < target; i++) @(negedge clk);
        check_output("event_count", events_seen, target);
    endtask

    initial begin
        logic [7:0] part;
        $display("[TB] start, CLKS_PER_BIT=%0d", CPB);

        // Reset state
        repeat (3) @(negedge clk);
        check_output("reset_rx_new", {31'd0, rx_new}, 32'd0);
        check_output("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check_output("reset_busy", {31'd0, busy}, 32'd0);
        check_output("reset_rx_data", {24'd0, rx_data}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 1: good byte 0xA5
        exp_q.push_back('{is_err: 1'b0, data: 8'hA5});
        apply_stimulus(8'hA5, 1'b1);
        wait_events(1, 4 * CPB);
        check_output("t1_busy_after", {31'd0, busy}, 32'd0);
        check_output("t1_data_held", {24'd0, rx_data}, 32'hA5);
        repeat (2 * CPB) @(negedge clk);

        // 2: short start glitch
        rx = 1'b0;
        repeat (4) @(negedge clk);
        check_output("t2_busy_during_glitch", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check_output("t2_busy_after", {31'd0, busy}, 32'd0);
        check_output("t2_data_kept", {24'd0, rx_data}, 32'hA5);
        check_output("t2_no_pulse", events_seen, 1);

        // 3: framing error followed by a break
        exp_q.push_back('{is_err: 1'b1, data: 8'hA5});
        apply_stimulus(8'h3C, 1'b0);
        repeat (40) @(negedge clk);
        check_output("t3_busy_in_break", {31'd0, busy}, 32'd1);
        wait_events(2, CPB);
        rx = 1'b1;
        repeat (6) @(negedge clk);
        check_output("t3_busy_after_break", {31'd0, busy}, 32'd0);
        check_output("t3_data_kept", {24'd0, rx_data}, 32'hA5);
        repeat (2 * CPB) @(negedge clk);

        // 4: back-to-back 0x00, 0xFF
        exp_q.push_back('{is_err: 1'b0, data: 8'h00});
        exp_q.push_back('{is_err: 1'b0, data: 8'hFF});
        apply_stimulus(8'h00, 1'b1);
        apply_stimulus(8'hFF, 1'b1);
        wait_events(4, 4 * CPB);
        check_output("t4_pulse_spacing", last_new_cycle - prev_new_cycle, 10 * CPB);
        repeat (2 * CPB) @(negedge clk);

        // 5: reset during data bit 4
        part = 8'h5A;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(part[i]);
        rx = part[4];
        repeat (CPB / 2) @(negedge clk);
        check_output("t5_busy_mid_frame", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        rx = 1'b1;
        @(negedge clk);
        check_output("t5_data_after_reset", {24'd0, rx_data}, 32'd0);
        check_output("t5_busy_in_reset", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check_output("t5_no_pulse_from_abort", events_seen, 4);
        exp_q.push_back('{is_err: 1'b0, data: 8'h5A});
        apply_stimulus(8'h5A, 1'b1);
        wait_events(5, 4 * CPB);
        repeat (2 * CPB) @(negedge clk);

        // 6: line low through reset release
        rx = 1'b0;
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        check_output("t6_busy_after_release", {31'd0, busy}, 32'd1);
        repeat (CPB - CPB / 2) @(negedge clk);
        part = 8'h96;
        exp_q.push_back('{is_err: 1'b0, data: 8'h96});
        for (int i = 0; i < 8; i++) drive_bit(part[i]);
        drive_bit(1'b1);
        wait_events(6, 4 * CPB);
        repeat (2 * CPB) @(negedge clk);

        check_output("no_x_on_outputs", {31'd0, x_seen}, 32'd0);
        check_output("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
